// File: rtl/alram_scan_reader.sv
// alram_scan_reader: sweeps a wrap-around address range on the alram1x read port.
// Define ALRAM_SCAN_ADDR_TAG_EN to add the dout_addr source-address tag.
module alram_scan_reader #(
    parameter int WID    = 10,
    parameter int AWID   = 2,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AWID-1:0] base,
    input  logic [AWID:0]   count,
    output logic            busy,
    output logic            done,
    output logic [AWID-1:0] ra,
    input  logic [WID-1:0]  rdo,
    output logic [WID-1:0]  dout,
    output logic            dout_valid,
    input  logic            dout_ready,
`ifdef ALRAM_SCAN_ADDR_TAG_EN
    output logic [AWID-1:0] dout_addr,
`endif
    output logic            dout_last
);

    localparam int DEPTH = RD_LAT + 1;
    localparam int CW    = $clog2(DEPTH + 1) + 1;
    localparam int SW    = CW + 1;
    localparam logic [AWID-1:0] ONE_A = 1;
    localparam logic [AWID:0]   ONE_R = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t            state;
    logic [AWID:0]     rem;
    logic [CW-1:0]     infl;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     wpos;
    logic [SW-1:0]     used;
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0] pl;
    logic [WID-1:0]    bd [DEPTH];
    logic [WID-1:0]    nd [DEPTH];
    logic [DEPTH-1:0]  bv;
    logic [DEPTH-1:0]  bl;
    logic [DEPTH-1:0]  nv;
    logic [DEPTH-1:0]  nl;
    logic              pop;
    logic              cap;
    logic              issue;
    logic              is_last;
`ifdef ALRAM_SCAN_ADDR_TAG_EN
    logic [AWID-1:0]   pa [RD_LAT];
    logic [AWID-1:0]   ba [DEPTH];
    logic [AWID-1:0]   na [DEPTH];

    assign dout_addr = ba[0];
`endif

    assign dout       = bd[0];
    assign dout_valid = bv[0];
    assign dout_last  = bl[0];

    assign pop     = bv[0] & dout_ready;
    assign cap     = pv[RD_LAT-1];
    assign is_last = (rem == ONE_R);
    assign wpos    = occ - CW'(pop);

    // A word leaving this cycle frees its slot for the address issued now.
    assign used  = SW'(infl) + SW'(occ) - SW'(pop);
    assign issue = (state == ISSUE) && (used < SW'(DEPTH));

    // Buffer head is entry 0; pop shifts down, capture fills the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nd[i] = bd[i];
`ifdef ALRAM_SCAN_ADDR_TAG_EN
            na[i] = ba[i];
`endif
        end
        nv = bv;
        nl = bl;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                nd[i] = bd[i+1];
`ifdef ALRAM_SCAN_ADDR_TAG_EN
                na[i] = ba[i+1];
`endif
            end
            nd[DEPTH-1] = '0;
`ifdef ALRAM_SCAN_ADDR_TAG_EN
            na[DEPTH-1] = '0;
`endif
            nv = bv >> 1;
            nl = bl >> 1;
        end
        if (cap) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wpos) begin
                    nd[i] = rdo;
                    nv[i] = 1'b1;
                    nl[i] = pl[RD_LAT-1];
`ifdef ALRAM_SCAN_ADDR_TAG_EN
                    na[i] = pa[RD_LAT-1];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv   <= '0;
            pl   <= '0;
            bv   <= '0;
            bl   <= '0;
            infl <= '0;
            occ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bd[i] <= '0;
`ifdef ALRAM_SCAN_ADDR_TAG_EN
                ba[i] <= '0;
`endif
            end
`ifdef ALRAM_SCAN_ADDR_TAG_EN
            for (int i = 0; i < RD_LAT; i++) begin
                pa[i] <= '0;
            end
`endif
        end else begin
            pv[0] <= issue;
            pl[0] <= issue && is_last;
`ifdef ALRAM_SCAN_ADDR_TAG_EN
            pa[0] <= ra;
`endif
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pl[i] <= pl[i-1];
`ifdef ALRAM_SCAN_ADDR_TAG_EN
                pa[i] <= pa[i-1];
`endif
            end
            bv <= nv;
            bl <= nl;
            for (int i = 0; i < DEPTH; i++) begin
                bd[i] <= nd[i];
`ifdef ALRAM_SCAN_ADDR_TAG_EN
                ba[i] <= na[i];
`endif
            end
            infl <= infl + CW'(issue) - CW'(cap);
            occ  <= occ + CW'(cap) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            ra    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (count != '0) begin
                            ra    <= base;
                            rem   <= count;
                            state <= ISSUE;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        ra  <= ra + ONE_A;
                        rem <= rem - ONE_R;
                        if (is_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (infl == '0 && occ == '0) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
